// File: rtl/timing_phase_search.sv
// timing_phase_search: sweeps the RX sample delay over phases 0-3, takes one LFSR-period
// squared-error reading per phase and locks on the lowest. Optional auto re-search: `PHASE_SEARCH_TRACK_EN.
module timing_phase_search #(
  parameter int unsigned SETTLE_PERIODS = 1,
  parameter logic [1:0]  DEFAULT_DELAY  = 2'd2,
  parameter int unsigned REARM_PERIODS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sym_clk_en,
  input  logic        cycle_out_periodic,
  input  logic [17:0] acc_sq_err_out,
  input  logic        start,
  output logic [1:0]  delay,
  output logic        busy,
  output logic        locked,
  output logic        done,
  output logic [17:0] best_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_SAMPLE,
    S_LOCKED
  } state_t;

  localparam logic [3:0] SettleLast = 4'(SETTLE_PERIODS - 1);

  state_t      state_q, state_d;
  logic [1:0]  delay_q, delay_d;
  logic [1:0]  best_delay_q, best_delay_d;
  logic [17:0] best_err_q, best_err_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic        busy_q, busy_d;
  logic        locked_q, locked_d;
  logic        done_q, done_d;

  logic        period_end;
  logic        better;
  logic        launch;

`ifdef PHASE_SEARCH_TRACK_EN
  localparam int unsigned RearmW = (REARM_PERIODS < 2) ? 1 : $clog2(REARM_PERIODS);
  localparam logic [RearmW-1:0] RearmLast = RearmW'(REARM_PERIODS - 1);
  logic [RearmW-1:0] rearm_cnt_q, rearm_cnt_d;
`else
  logic unused_rearm;
  assign unused_rearm = (REARM_PERIODS == 0);
`endif

  assign period_end = cycle_out_periodic & sym_clk_en;
  assign better     = acc_sq_err_out < best_err_q;

  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    best_delay_d = best_delay_q;
    best_err_d   = best_err_q;
    settle_cnt_d = settle_cnt_q;
    busy_d       = busy_q;
    locked_d     = locked_q;
    done_d       = 1'b0;
    launch       = 1'b0;
`ifdef PHASE_SEARCH_TRACK_EN
    rearm_cnt_d  = rearm_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) launch = 1'b1;
      end
      S_SETTLE: begin
        if (SETTLE_PERIODS == 0) begin
          state_d = S_MEASURE;
        end else if (period_end) begin
          if (settle_cnt_q == SettleLast) state_d = S_MEASURE;
          else settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      S_MEASURE: begin
        if (period_end) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (sym_clk_en) begin
          if (better) begin
            best_err_d   = acc_sq_err_out;
            best_delay_d = delay_q;
          end
          if (delay_q != 2'd3) begin
            delay_d      = delay_q + 2'd1;
            settle_cnt_d = '0;
            state_d      = S_SETTLE;
          end else begin
            // Phase 3's own result must be folded in before choosing the final delay.
            delay_d  = better ? delay_q : best_delay_q;
            state_d  = S_LOCKED;
            busy_d   = 1'b0;
            locked_d = 1'b1;
            done_d   = 1'b1;
`ifdef PHASE_SEARCH_TRACK_EN
            rearm_cnt_d = '0;
`endif
          end
        end
      end
      S_LOCKED: begin
        if (start) begin
          launch = 1'b1;
`ifdef PHASE_SEARCH_TRACK_EN
        end else if (period_end) begin
          if (rearm_cnt_q == RearmLast) launch = 1'b1;
          else rearm_cnt_d = rearm_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d      = S_SETTLE;
      delay_d      = 2'd0;
      best_delay_d = 2'd0;
      best_err_d   = '1;
      settle_cnt_d = '0;
      busy_d       = 1'b1;
      locked_d     = 1'b0;
`ifdef PHASE_SEARCH_TRACK_EN
      rearm_cnt_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      delay_q      <= DEFAULT_DELAY;
      best_delay_q <= 2'd0;
      best_err_q   <= '1;
      settle_cnt_q <= '0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      done_q       <= 1'b0;
`ifdef PHASE_SEARCH_TRACK_EN
      rearm_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      best_delay_q <= best_delay_d;
      best_err_q   <= best_err_d;
      settle_cnt_q <= settle_cnt_d;
      busy_q       <= busy_d;
      locked_q     <= locked_d;
      done_q       <= done_d;
`ifdef PHASE_SEARCH_TRACK_EN
      rearm_cnt_q  <= rearm_cnt_d;
`endif
    end
  end

  assign delay    = delay_q;
  assign busy     = busy_q;
  assign locked   = locked_q;
  assign done     = done_q;
  assign best_err = best_err_q;

endmodule

// File: tb/tb_timing_phase_search.sv
// Directed bench for timing_phase_search: per-delay error table drives acc_sq_err_out,
// a monitor pops expected phase/result values from scoreboard queues.
module tb_timing_phase_search;

  localparam int unsigned SETTLE = 1;
  localparam int unsigned REARM  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_clk_en = 1'b0;
  logic        cycle_out_periodic = 1'b0;
  logic        start = 1'b0;
  logic [17:0] acc_sq_err_out;
  logic [1:0]  delay;
  logic        busy, locked, done;
  logic [17:0] best_err;

  logic [17:0] err_tab [4];
  int total = 0;
  int bad = 0;
  int exp_delay_q [$];
  int exp_err_q [$];
  int done_cnt = 0;
  int pe_cnt = 0;
  int lock_pe = 0;
  logic       prev_busy = 1'b0;
  logic       prev_done = 1'b0;
  logic [1:0] prev_delay = 2'd0;

  always #5 clk = ~clk;

  assign acc_sq_err_out = err_tab[delay];

  timing_phase_search #(
    .SETTLE_PERIODS(SETTLE),
    .DEFAULT_DELAY (2'd2),
    .REARM_PERIODS (REARM)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .sym_clk_en        (sym_clk_en),
    .cycle_out_periodic(cycle_out_periodic),
    .acc_sq_err_out    (acc_sq_err_out),
    .start             (start),
    .delay             (delay),
    .busy              (busy),
    .locked            (locked),
    .done              (done),
    .best_err          (best_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Symbol every 4 clks, period end every 8 symbols; an unqualified marker one clk early must be ignored.
  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #2;
      c++;
      sym_clk_en         = (c % 4 == 0);
      cycle_out_periodic = (c % 32 == 0) || (c % 32 == 31);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy  = 1'b0;
        prev_done  = 1'b0;
        prev_delay = delay;
        pe_cnt     = 0;
      end else begin
        if (prev_done) chk("done_one_clk", done, 0);
        if (busy && !prev_busy) begin
          chk("start_delay", delay, 0);
          chk("start_best_err", best_err, 18'h3FFFF);
          chk("start_locked", locked, 0);
          pe_cnt = 0;
        end else if (prev_busy && (delay != prev_delay || !busy)) begin
          chk("phase_periods", pe_cnt, SETTLE + 1);
          pe_cnt = 0;
          if (exp_delay_q.size() == 0) chk("sb_delay_pending", exp_delay_q.size(), 1);
          else chk("phase_delay", delay, exp_delay_q.pop_front());
          if (!busy) begin
            chk("done_pulse", done, 1);
            chk("locked_at_done", locked, 1);
            if (exp_err_q.size() == 0) chk("sb_err_pending", exp_err_q.size(), 1);
            else chk("best_err", best_err, exp_err_q.pop_front());
            done_cnt++;
          end else begin
            chk("no_done_mid_search", done, 0);
          end
        end else if (done && !prev_done) begin
          chk("spurious_done", done, 0);
        end
        if (busy) pe_cnt += int'(cycle_out_periodic & sym_clk_en);
        if (done) lock_pe = 0;
        if (locked) lock_pe += int'(cycle_out_periodic & sym_clk_en);
        prev_busy  = busy;
        prev_done  = done;
        prev_delay = delay;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_search(input logic [17:0] e0, input logic [17:0] e1,
                             input logic [17:0] e2, input logic [17:0] e3);
    int bd = 0;
    logic [17:0] be = 18'h3FFFF;
    err_tab[0] = e0;
    err_tab[1] = e1;
    err_tab[2] = e2;
    err_tab[3] = e3;
    for (int d = 0; d < 4; d++) begin
      if (err_tab[d] < be) begin
        be = err_tab[d];
        bd = d;
      end
    end
    exp_delay_q.push_back(1);
    exp_delay_q.push_back(2);
    exp_delay_q.push_back(3);
    exp_delay_q.push_back(bd);
    exp_err_q.push_back(int'(be));
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_clks);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < max_clks) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    int n;
    int viol;
    err_tab[0] = 18'd0; err_tab[1] = 18'd0; err_tab[2] = 18'd0; err_tab[3] = 18'd0;

    // 1: reset values, then idle for 10 periods
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_delay", delay, 2);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_done", done, 0);
    chk("rst_best_err", best_err, 18'h3FFFF);
    @(posedge clk); #2 reset = 1'b1;
    for (int p = 0; p < 10; p++) begin
      repeat (32) @(negedge clk);
      chk("idle_delay", delay, 2);
      chk("idle_busy", busy, 0);
    end
    chk("idle_locked", locked, 0);
    chk("idle_best_err", best_err, 18'h3FFFF);

    // 2: distinct errors, best at delay 2; start->busy latency of one clk
    push_search(18'd900, 18'd400, 18'd150, 18'd700);
    @(posedge clk); #2 start = 1'b1;
    @(negedge clk);
    chk("busy_before_edge", busy, 0);
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    chk("busy_one_clk", busy, 1);
    wait_done("t2_done", 600);
    chk("t2_delay", delay, 2);
    chk("t2_best_err", best_err, 150);

    // 3: ties keep the lowest delay
    push_search(18'd300, 18'd300, 18'd500, 18'd300);
    pulse_start();
    wait_done("t3_done", 600);
    chk("t3_delay", delay, 0);
    chk("t3_best_err", best_err, 300);

    // 4: start held high: one search, then immediate restart from LOCKED
    push_search(18'd600, 18'd250, 18'd250, 18'd100);
    @(posedge clk); #2 start = 1'b1;
    wait_done("t4_done", 600);
    chk("t4_delay", delay, 3);
    push_search(18'd600, 18'd250, 18'd250, 18'd100);
    @(negedge clk); #1;
    chk("t4_restart_busy", busy, 1);
    chk("t4_restart_locked", locked, 0);
    @(posedge clk); #2 start = 1'b0;
    wait_done("t4_second_done", 600);

    // 5: reset during SETTLE of delay 2 aborts without done
    push_search(18'd900, 18'd400, 18'd150, 18'd700);
    pulse_start();
    n = 0;
    while (!(busy && delay == 2'd2) && n < 600) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t5_reach_delay2", busy && delay == 2'd2, 1);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    exp_delay_q.delete();
    exp_err_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    chk("t5_abort_delay", delay, 2);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done, 0);
    chk("t5_abort_best_err", best_err, 18'h3FFFF);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (100) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_delay", delay, 2);
    push_search(18'd900, 18'd400, 18'd150, 18'd700);
    pulse_start();
    wait_done("t5_done", 600);
    chk("t5_delay", delay, 2);

    // 6: behaviour while locked
`ifdef PHASE_SEARCH_TRACK_EN
    push_search(18'd500, 18'd200, 18'd800, 18'd900);
    n = 0;
    while (!busy && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t6_rearm_busy", busy, 1);
    chk("t6_rearm_periods", lock_pe, REARM);
    wait_done("t6_second_done", 600);
    chk("t6_delay", delay, 1);
`else
    viol = 0;
    d0 = done_cnt;
    for (int i = 0; i < 50 * 32; i++) begin
      @(negedge clk);
      if (locked !== 1'b1 || busy !== 1'b0) viol++;
    end
    chk("t6_hold_violations", viol, 0);
    chk("t6_no_rearm", done_cnt - d0, 0);
    chk("t6_delay", delay, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
